// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store unit driving the data port of a byte-addressed unified memory
// One request in flight: IDLE accepts, ACCESS drives memory, RESP holds the response until taken.
module lsu_mem_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [3:0]            mem_byte_en
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state_q;
  logic                    we_q;
  logic [2:0]              f3_q;
  logic [1:0]              off_q;
  logic                    legal_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic                    mem_wr_en_q;
  logic [3:0]              mem_byte_en_q;
  logic [DATA_WIDTH-1:0]   mem_wr_data_q;

  logic [1:0]              req_off;
  logic                    req_legal;
  logic [3:0]              base_mask;
  logic [3:0]              mem_byte_en_d;
  logic [DATA_WIDTH-1:0]   mem_wr_data_d;
  logic [DATA_WIDTH-1:0]   ld_lane;
  logic [DATA_WIDTH-1:0]   rsp_rdata_d;
  logic                    rsp_err_d;

  function automatic logic is_legal(input logic we, input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  is_legal = 1'b1;
      3'b001:  is_legal = ~off[0];
      3'b010:  is_legal = (off == 2'b00);
      3'b100:  is_legal = ~we;
      3'b101:  is_legal = ~we & ~off[0];
      default: is_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    req_off   = req_addr[1:0];
    req_legal = is_legal(req_we, req_funct3, req_off);
    base_mask = 4'b0000;
    case (req_funct3[1:0])
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      2'b10:   base_mask = 4'b1111;
      default: base_mask = 4'b0000;
    endcase
    mem_byte_en_d = (req_legal && req_we) ? (base_mask << req_off) : 4'b0000;
    mem_wr_data_d = req_wdata << {req_off, 3'b000};
  end

  // Load extraction uses the captured request; mem_rd_data is valid for mem_addr during ACCESS.
  always_comb begin
    ld_lane     = mem_rd_data >> {off_q, 3'b000};
    rsp_rdata_d = '0;
    case (f3_q)
      3'b000:  rsp_rdata_d = {{(DATA_WIDTH-8){ld_lane[7]}}, ld_lane[7:0]};
      3'b001:  rsp_rdata_d = {{(DATA_WIDTH-16){ld_lane[15]}}, ld_lane[15:0]};
      3'b100:  rsp_rdata_d = {{(DATA_WIDTH-8){1'b0}}, ld_lane[7:0]};
      3'b101:  rsp_rdata_d = {{(DATA_WIDTH-16){1'b0}}, ld_lane[15:0]};
      3'b010:  rsp_rdata_d = ld_lane;
      default: rsp_rdata_d = '0;
    endcase
    rsp_err_d = ~legal_q;
    if (!legal_q || we_q) begin
      rsp_rdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      legal_q       <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_byte_en_q <= 4'b0000;
      mem_wr_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q       <= ACCESS;
            we_q          <= req_we;
            f3_q          <= req_funct3;
            off_q         <= req_off;
            legal_q       <= req_legal;
            mem_addr_q    <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wr_en_q   <= req_legal & req_we;
            mem_byte_en_q <= mem_byte_en_d;
            mem_wr_data_q <= mem_wr_data_d;
          end
        end
        ACCESS: begin
          state_q       <= RESP;
          rsp_rdata_q   <= rsp_rdata_d;
          rsp_err_q     <= rsp_err_d;
          mem_addr_q    <= '0;
          mem_wr_en_q   <= 1'b0;
          mem_byte_en_q <= 4'b0000;
          mem_wr_data_q <= '0;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_addr = mem_addr_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_byte_en = mem_byte_en_q;
  assign mem_wr_data = mem_wr_data_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - directed self-checking bench for lsu_mem_port
// A behavioural word memory sits behind the data port; expected values are hand-computed.
module tb_lsu_mem_port;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd_data;
  logic        mem_wr_en;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_byte_en;

  int tests;
  int fails;
  int wr_cnt;

  logic [31:0] mem [0:1023];

  lsu_mem_port #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_byte_en(mem_byte_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      for (int b = 0; b < 4; b++) begin
        if (mem_byte_en[b]) mem[mem_wr_addr[11:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
      end
    end
  end

  logic [31:0] t_rdata;
  logic        t_err;
  int          t_lat;
  logic [3:0]  t_be;
  logic [31:0] t_wd;
  logic        t_wen;

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata);
    int cnt;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    cnt = 0;
    while (!req_ready && cnt < 20) begin @(negedge clk); cnt++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    t_be = mem_byte_en; t_wd = mem_wr_data; t_wen = mem_wr_en;
    t_lat = 1;
    while (!rsp_valid && t_lat < 20) begin @(negedge clk); t_lat++; end
    if (!rsp_valid) begin
      tests++; fails++;
      $display("FAIL txn_timeout addr=%h rsp_valid never rose", addr);
    end
    t_rdata = rsp_rdata; t_err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({req_ready, rsp_valid, rsp_err, mem_wr_en} !== 4'b1000) begin
      fails++; $display("FAIL reset_ctrl got=%b want=1000", {req_ready, rsp_valid, rsp_err, mem_wr_en});
    end
    tests++;
    if ({rsp_rdata, mem_addr, mem_wr_data, mem_byte_en} !== 100'd0) begin
      fails++; $display("FAIL reset_data rdata=%h addr=%h wd=%h be=%b want all 0",
                        rsp_rdata, mem_addr, mem_wr_data, mem_byte_en);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_word;
    txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    tests++;
    if (t_be !== 4'b1111 || t_wen !== 1'b1 || t_wd !== 32'hDEADBEEF) begin
      fails++; $display("FAIL sw_drive be=%b wen=%b wd=%h want 1111 1 deadbeef", t_be, t_wen, t_wd);
    end
    tests++;
    if (t_rdata !== 32'h0 || t_err !== 1'b0 || t_lat != 2) begin
      fails++; $display("FAIL sw_rsp rdata=%h err=%b lat=%0d want 0 0 2", t_rdata, t_err, t_lat);
    end
    txn(1'b0, 3'b010, 32'h100, 32'h0);
    tests++;
    if (t_rdata !== 32'hDEADBEEF || t_err !== 1'b0 || t_lat != 2 || t_wen !== 1'b0) begin
      fails++; $display("FAIL lw_rsp rdata=%h err=%b lat=%0d wen=%b want deadbeef 0 2 0",
                        t_rdata, t_err, t_lat, t_wen);
    end
  endtask

  task automatic test_load_ext;
    logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] adrs [4] = '{32'h203, 32'h203, 32'h202, 32'h200};
    logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
    mem[32'h200 >> 2] = 32'h80FF7F01;
    for (int i = 0; i < 4; i++) begin
      txn(1'b0, f3s[i], adrs[i], 32'h0);
      tests++;
      if (t_rdata !== exps[i] || t_err !== 1'b0) begin
        fails++; $display("FAIL load_ext[%0d] rdata=%h err=%b want %h 0", i, t_rdata, t_err, exps[i]);
      end
    end
  endtask

  task automatic test_half_store;
    mem[32'h300 >> 2] = 32'hAAAAAAAA;
    txn(1'b1, 3'b001, 32'h302, 32'h00001234);
    tests++;
    if (t_be !== 4'b1100 || t_wd !== 32'h12340000 || t_wen !== 1'b1) begin
      fails++; $display("FAIL sh_drive be=%b wd=%h wen=%b want 1100 12340000 1", t_be, t_wd, t_wen);
    end
    txn(1'b0, 3'b010, 32'h300, 32'h0);
    tests++;
    if (t_rdata !== 32'h1234AAAA) begin
      fails++; $display("FAIL sh_readback rdata=%h want 1234aaaa", t_rdata);
    end
  endtask

  task automatic test_errors;
    logic        wes  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s  [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [31:0] adrs [4] = '{32'h101, 32'h103, 32'h100, 32'h100};
    int wr0;
    wr0 = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      txn(wes[i], f3s[i], adrs[i], 32'h55555555);
      tests++;
      if (t_err !== 1'b1 || t_rdata !== 32'h0 || t_wen !== 1'b0 || t_be !== 4'b0000) begin
        fails++; $display("FAIL err[%0d] err=%b rdata=%h wen=%b be=%b want 1 0 0 0000",
                          i, t_err, t_rdata, t_wen, t_be);
      end
    end
    tests++;
    if (wr_cnt != wr0 || mem[32'h100 >> 2] !== 32'hDEADBEEF) begin
      fails++; $display("FAIL err_no_write writes=%0d word=%h want 0 deadbeef", wr_cnt - wr0, mem[32'h100 >> 2]);
    end
  endtask

  task automatic test_backpressure;
    int cnt;
    int wr0;
    int bad;
    wr0 = wr_cnt;
    bad = 0;
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h200; req_wdata = 32'h0BADF00D;
    cnt = 0;
    while (!rsp_valid && cnt < 20) begin @(negedge clk); cnt++; end
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0 || req_ready !== 1'b0)
        bad++;
      @(negedge clk);
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL backpressure_hold bad_cycles=%0d want 0 (valid=%b rdata=%h rdy=%b)",
                        bad, rsp_valid, rsp_rdata, req_ready);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || wr_cnt != wr0 || mem[32'h200 >> 2] !== 32'h80FF7F01) begin
      fails++; $display("FAIL backpressure_release rdy=%b valid=%b writes=%0d word=%h want 1 0 0 80ff7f01",
                        req_ready, rsp_valid, wr_cnt - wr0, mem[32'h200 >> 2]);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    mem[32'h400 >> 2] = 32'h55555555;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h400; req_wdata = 32'h11223344; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    tests++;
    if (mem_wr_en !== 1'b1) begin
      fails++; $display("FAIL rst_mid_pre wen=%b want 1", mem_wr_en);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (mem_wr_en !== 1'b0 || mem_byte_en !== 4'b0000) begin
      fails++; $display("FAIL rst_mid_drop wen=%b be=%b want 0 0000", mem_wr_en, mem_byte_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    tests++;
    if (seen != 0 || req_ready !== 1'b1 || mem[32'h400 >> 2] !== 32'h55555555) begin
      fails++; $display("FAIL rst_mid_after rsp_seen=%0d rdy=%b word=%h want 0 1 55555555",
                        seen, req_ready, mem[32'h400 >> 2]);
    end
  endtask

  initial begin
    tests = 0; fails = 0; wr_cnt = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    test_reset;
    test_word;
    test_load_ext;
    test_half_store;
    test_errors;
    test_backpressure;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
